// File: rtl/bus_arbiter.sv
// bus_arbiter: per-segment bus ownership for multiple masters, switched on M-cycle boundaries
module bus_arbiter #(
  parameter int NM = 3,
  parameter int NS = 3,
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int RR = 0,
  parameter int MAX_LOCK = 160,
  localparam int SW = NS > 1 ? $clog2(NS) : 1,
  localparam int MW = NM > 1 ? $clog2(NM) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mc_end,
  input  logic [NM-1:0]    m_req,
  input  logic [NM*SW-1:0] m_seg,
  input  logic [NM-1:0]    m_lock,
  input  logic [NM-1:0]    m_rd,
  input  logic [NM-1:0]    m_wr,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*DW-1:0] m_wdata,
  output logic [NM-1:0]    m_gnt,
  output logic [NM*DW-1:0] m_rdata,
  output logic [NS-1:0]    s_rd,
  output logic [NS-1:0]    s_wr,
  output logic [NS*AW-1:0] s_addr,
  output logic [NS*DW-1:0] s_wdata,
  input  logic [NS*DW-1:0] s_rdata,
  output logic [NS*MW-1:0] s_owner,
  output logic [NS-1:0]    s_busy
);
  localparam int LW = MAX_LOCK > 1 ? $clog2(MAX_LOCK) : 1;
  logic [NS-1:0] busy;
  logic [MW-1:0] owner [NS];
  for (genvar s = 0; s < NS; s++) begin : g_seg
    logic          busy_q, busy_d, hold, forced;
    logic [MW-1:0] owner_q, owner_d, ptr_q, ptr_d, win, rr_win;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [NM-1:0] cand, pool;
    int            best;
    // keep a locked owner under the limit, otherwise arbitrate among this segment's requesters
    always_comb begin
      cand = '0;
      for (int i = 0; i < NM; i++) cand[i] = m_req[i] && m_seg[i*SW +: SW] == SW'(s);
      hold = busy_q && cand[owner_q] && m_lock[owner_q] && (MAX_LOCK == 0 || int'(cnt_q) < MAX_LOCK - 1);
      forced = busy_q && cand[owner_q] && m_lock[owner_q] && !hold;
      pool = forced && |(cand & ~(NM'(1) << owner_q)) ? cand & ~(NM'(1) << owner_q) : cand;
      win = '0;
      rr_win = '0;
      best = NM;
      for (int i = 0; i < NM; i++)
        if (pool[i]) begin
          win = MW'(i);
          if ((i - int'(ptr_q) + NM) % NM < best) begin
            best = (i - int'(ptr_q) + NM) % NM;
            rr_win = MW'(i);
          end
        end
      busy_d = hold || |pool;
      owner_d = hold ? owner_q : RR != 0 ? rr_win : win;
      cnt_d = hold && MAX_LOCK != 0 ? cnt_q + LW'(1) : '0;
      ptr_d = RR != 0 && !hold && |pool ? MW'((int'(rr_win) + 1) % NM) : ptr_q;
    end
    // ownership registers advance only on the last T-cycle of an M-cycle
    always_ff @(posedge clk)
      if (!rst) begin
        busy_q <= 1'b0;
        owner_q <= '0;
        ptr_q <= '0;
        cnt_q <= '0;
      end else if (mc_end) begin
        busy_q <= busy_d;
        owner_q <= owner_d;
        ptr_q <= ptr_d;
        cnt_q <= cnt_d;
      end
    assign busy[s] = busy_q;
    assign owner[s] = owner_q;
    assign s_busy[s] = busy_q;
    assign s_owner[s*MW +: MW] = owner_q;
    assign s_rd[s] = rst && busy_q && m_rd[owner_q];
    assign s_wr[s] = rst && busy_q && m_wr[owner_q];
    assign s_addr[s*AW +: AW] = busy_q ? m_addr[owner_q*AW +: AW] : '0;
    assign s_wdata[s*DW +: DW] = busy_q ? m_wdata[owner_q*DW +: DW] : '0;
  end
  for (genvar i = 0; i < NM; i++) begin : g_m
    logic [SW-1:0] sg;
    logic          gnt;
    assign sg = m_seg[i*SW +: SW];
    assign gnt = int'(sg) < NS && busy[sg] && owner[sg] == MW'(i);
    assign m_gnt[i] = gnt;
    assign m_rdata[i*DW +: DW] = gnt ? s_rdata[sg*DW +: DW] : '1;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: fixed-priority/limited-lock and round-robin/unlimited instances against a queue-based model
module tb_bus_arbiter;
  localparam int NM = 3, NS = 3, AW = 16, DW = 8, SW = 2, MW = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [1:0] ct = '0;
  logic mc_end;
  always @(posedge clk) ct <= ct + 2'd1;
  assign mc_end = ct == 2'd3;
  logic [NM-1:0] m_req, m_lock, m_rd, m_wr;
  logic [NM*SW-1:0] m_seg;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [NM-1:0] gnt [2];
  logic [NM*DW-1:0] rdata [2];
  logic [NS-1:0] srd [2], swr [2], sbusy [2];
  logic [NS*AW-1:0] saddr [2];
  logic [NS*DW-1:0] swdata [2];
  logic [NS*MW-1:0] sown [2];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    bus_arbiter #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .RR(g), .MAX_LOCK(g == 0 ? 4 : 0)) u (
      .clk(clk), .rst(rst), .mc_end(mc_end), .m_req(m_req), .m_seg(m_seg), .m_lock(m_lock),
      .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(gnt[g]),
      .m_rdata(rdata[g]), .s_rd(srd[g]), .s_wr(swr[g]), .s_addr(saddr[g]), .s_wdata(swdata[g]),
      .s_rdata(s_rdata), .s_owner(sown[g]), .s_busy(sbusy[g]));
  end
  int tests = 0, fails = 0;
  bit owned [2][NS];
  int own [2][NS], cnt [2][NS], ptr [2][NS];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // instance 0: highest index wins, lock limit 4; instance 1: round-robin, unlimited lock
  function automatic void nxt(input int k, input int s, output bit o, output int w, output int c2, output int p);
    int c[$], d[$];
    int ml, ow;
    bit ownc;
    ml = k == 0 ? 4 : 0;
    ow = own[k][s];
    o = owned[k][s];
    w = ow;
    c2 = cnt[k][s];
    p = ptr[k][s];
    ownc = 0;
    for (int i = 0; i < NM; i++)
      if (m_req[i] && int'(m_seg[i*SW +: SW]) == s) begin
        c.push_back(i);
        if (i == ow) ownc = 1;
      end
    if (o && ownc && m_lock[ow]) begin
      if (ml == 0 || c2 < ml - 1) begin
        c2 += ml != 0 ? 1 : 0;
        return;
      end
      if (c.size() > 1) begin
        foreach (c[j]) if (c[j] != ow) d.push_back(c[j]);
        c = d;
      end
    end
    c2 = 0;
    o = c.size() != 0;
    if (!o) return;
    if (k == 0) w = c[c.size()-1];
    else begin
      w = -1;
      foreach (c[j]) if (w < 0 && c[j] >= p) w = c[j];
      if (w < 0) w = c[0];
      p = (w + 1) % NM;
    end
  endfunction
  always @(posedge clk) begin : mdl
    bit o;
    int w, c2, p;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < NS; s++)
        if (!rst) begin
          owned[k][s] <= 0;
          own[k][s] <= 0;
          cnt[k][s] <= 0;
          ptr[k][s] <= 0;
        end else if (mc_end) begin
          nxt(k, s, o, w, c2, p);
          owned[k][s] <= o;
          own[k][s] <= w;
          cnt[k][s] <= c2;
          ptr[k][s] <= p;
        end
  end
  always @(negedge clk) begin : cmp
    logic [NM-1:0] eg;
    logic [NM*DW-1:0] er;
    logic [NS-1:0] eb, erd, ewr;
    logic [NS*AW-1:0] ea;
    logic [NS*DW-1:0] ew;
    logic [NS*MW-1:0] eo, em;
    int sg, o;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NM; i++) begin
        sg = int'(m_seg[i*SW +: SW]);
        eg[i] = 1'b0;
        if (sg < NS) eg[i] = owned[k][sg] && own[k][sg] == i;
        er[i*DW +: DW] = eg[i] ? s_rdata[sg*DW +: DW] : 8'hFF;
      end
      for (int s = 0; s < NS; s++) begin
        o = own[k][s];
        eb[s] = owned[k][s];
        erd[s] = rst && owned[k][s] && m_rd[o];
        ewr[s] = rst && owned[k][s] && m_wr[o];
        ea[s*AW +: AW] = owned[k][s] ? m_addr[o*AW +: AW] : '0;
        ew[s*DW +: DW] = owned[k][s] ? m_wdata[o*DW +: DW] : '0;
        em[s*MW +: MW] = owned[k][s] ? '1 : '0;
        eo[s*MW +: MW] = owned[k][s] ? MW'(o) : '0;
      end
      chk($sformatf("u%0d m_gnt", k), 64'(gnt[k]), 64'(eg));
      chk($sformatf("u%0d m_rdata", k), 64'(rdata[k]), 64'(er));
      chk($sformatf("u%0d s_busy", k), 64'(sbusy[k]), 64'(eb));
      chk($sformatf("u%0d s_rd", k), 64'(srd[k]), 64'(erd));
      chk($sformatf("u%0d s_wr", k), 64'(swr[k]), 64'(ewr));
      chk($sformatf("u%0d s_addr", k), 64'(saddr[k]), 64'(ea));
      chk($sformatf("u%0d s_wdata", k), 64'(swdata[k]), 64'(ew));
      chk($sformatf("u%0d s_owner", k), 64'(sown[k] & em), 64'(eo));
    end
  end
  task automatic mcycle();
    do begin
      @(posedge clk);
      #1;
    end while (ct != 2'd0);
  endtask
  task automatic set_m(input int i, input bit rq, input int sg, input bit lk, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req[i] = rq;
    m_seg[i*SW +: SW] = SW'(sg);
    m_lock[i] = lk;
    m_rd[i] = rd;
    m_wr[i] = wr;
    m_addr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = d;
  endtask
  task automatic clr();
    m_req = '0;
    m_lock = '0;
    m_rd = '0;
    m_wr = '0;
  endtask
  initial begin
    int exp4[4];
    int exp5[6];
    exp4 = '{0, 1, 2, 0};
    exp5 = '{1, 1, 1, 1, 0, 1};
    rst = 1'b0;
    clr();
    m_seg = '0;
    m_addr = '0;
    m_wdata = '0;
    s_rdata = {8'h5A, 8'hC3, 8'h3C};
    set_m(0, 1, 0, 0, 1, 0, 16'h0100, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d reset gnt", k), 64'(gnt[k]), 64'(0));
      chk($sformatf("u%0d reset busy", k), 64'(sbusy[k]), 64'(0));
      chk($sformatf("u%0d reset rdata", k), 64'(rdata[k]), 64'(24'hFFFFFF));
      chk($sformatf("u%0d reset owner", k), 64'(sown[k]), 64'(0));
      chk($sformatf("u%0d reset s_rd", k), 64'(srd[k]), 64'(0));
    end
    rst = 1'b1;
    clr();
    mcycle();
    @(posedge clk);
    #1;
    set_m(0, 1, 0, 0, 1, 0, 16'h1234, 8'h00);
    for (int k = 0; k < 2; k++) chk($sformatf("u%0d cpu early gnt", k), 64'(gnt[k]), 64'(0));
    mcycle();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d cpu gnt", k), 64'(gnt[k]), 64'(3'b001));
      chk($sformatf("u%0d cpu rdata", k), 64'(rdata[k][7:0]), 64'(8'h3C));
      chk($sformatf("u%0d cpu s_rd", k), 64'(srd[k]), 64'(3'b001));
      chk($sformatf("u%0d cpu s_addr", k), 64'(saddr[k][15:0]), 64'(16'h1234));
    end
    set_m(0, 1, 1, 0, 0, 1, 16'h8000, 8'h77);
    set_m(2, 1, 1, 0, 0, 0, 16'h9000, 8'h00);
    mcycle();
    chk("u0 prio gnt", 64'(gnt[0]), 64'(3'b100));
    chk("u0 prio cpu rdata", 64'(rdata[0][7:0]), 64'(8'hFF));
    chk("u0 prio dropped wr", 64'(swr[0]), 64'(0));
    chk("u0 prio owner", 64'(sown[0][3:2]), 64'(2));
    chk("u0 prio busy", 64'(sbusy[0]), 64'(3'b010));
    chk("u1 rr gnt", 64'(gnt[1]), 64'(3'b001));
    chk("u1 rr wr", 64'(swr[1]), 64'(3'b010));
    chk("u1 rr addr", 64'(saddr[1][31:16]), 64'(16'h8000));
    chk("u1 rr rdata", 64'(rdata[1][7:0]), 64'(8'hC3));
    clr();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < NM; i++) set_m(i, 1, 2, 0, 1, 0, 16'hFE00 + AW'(i), 8'h00);
    for (int b = 0; b < 4; b++) begin
      mcycle();
      chk($sformatf("u1 rotate %0d", b), 64'(sown[1][5:4]), 64'(exp4[b]));
    end
    chk("u0 rotate fixed", 64'(sown[0][5:4]), 64'(2));
    clr();
    mcycle();
    set_m(1, 1, 2, 1, 0, 0, 16'hFE01, 8'h00);
    set_m(0, 1, 2, 0, 0, 0, 16'hFE00, 8'h00);
    for (int b = 0; b < 6; b++) begin
      mcycle();
      chk($sformatf("u0 lock %0d", b), 64'(sown[0][5:4]), 64'(exp5[b]));
      chk($sformatf("u0 lock busy %0d", b), 64'(sbusy[0][2]), 64'(1));
      chk($sformatf("u1 lock %0d", b), 64'(sown[1][5:4]), 64'(1));
    end
    clr();
    set_m(1, 1, 2, 0, 1, 0, 16'hFE80, 8'h00);
    set_m(0, 1, 0, 0, 0, 1, 16'hC000, 8'h42);
    mcycle();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d disjoint gnt", k), 64'(gnt[k]), 64'(3'b011));
      chk($sformatf("u%0d disjoint addr0", k), 64'(saddr[k][15:0]), 64'(16'hC000));
      chk($sformatf("u%0d disjoint addr2", k), 64'(saddr[k][47:32]), 64'(16'hFE80));
      chk($sformatf("u%0d disjoint wr", k), 64'(swr[k]), 64'(3'b001));
      chk($sformatf("u%0d disjoint rd", k), 64'(srd[k]), 64'(3'b100));
      chk($sformatf("u%0d disjoint wdata", k), 64'(swdata[k][7:0]), 64'(8'h42));
    end
    set_m(1, 1, 2, 1, 1, 0, 16'hFE80, 8'h00);
    mcycle();
    for (int k = 0; k < 2; k++) chk($sformatf("u%0d burst rd", k), 64'(srd[k]), 64'(3'b100));
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d abort rd", k), 64'(srd[k]), 64'(0));
      chk($sformatf("u%0d abort wr", k), 64'(swr[k]), 64'(0));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("u%0d abort gnt", k), 64'(gnt[k]), 64'(0));
    rst = 1'b1;
    clr();
    repeat (4000) begin
      if (ct == 2'd0) begin
        m_req = NM'($urandom);
        m_lock = NM'($urandom | $urandom);
        m_seg = (NM*SW)'($urandom);
      end
      m_rd = NM'($urandom);
      m_wr = NM'($urandom);
      m_addr = (NM*AW)'({$urandom, $urandom});
      m_wdata = (NM*DW)'($urandom);
      s_rdata = (NS*DW)'($urandom);
      rst = $urandom_range(0, 99) != 0;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
